axi4_read_arbiter: RTL

AXI4_READ_ARBITER -- requirements
Module: axi4_read_arbiter

---
 rtl/axi4_pkg.sv | 18 +
 rtl/axi4_rr_pick2.sv | 13 +
 rtl/axi4_read_arbiter.sv | 118 +++++++++++
 3 files changed

// File: rtl/axi4_pkg.sv
// rtl/axi4_pkg.sv - shared types and constants for the AXI4 read arbiter
package axi4_pkg;

    localparam int AXI4_ADDR_W = 64;
    localparam int AXI4_DATA_W = 64;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADDR = 2'd1,
        ST_DATA = 2'd2
    } arb_state_t;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

endpackage

// File: rtl/axi4_rr_pick2.sv
// rtl/axi4_rr_pick2.sv - two-way round-robin winner select
module axi4_rr_pick2 (
    input  logic [1:0] req,
    input  logic       last,
    output logic       gnt_valid,
    output logic       gnt_idx
);

    // On a tie the requester that did not win last time goes first.
    assign gnt_valid = |req;
    assign gnt_idx   = (req == 2'b11) ? ~last : req[1];

endmodule

// File: rtl/axi4_read_arbiter.sv
// rtl/axi4_read_arbiter.sv - two-requester AXI4 read arbiter, one read outstanding
module axi4_read_arbiter
    import axi4_pkg::*;
#(
    parameter int ADDR_W = AXI4_ADDR_W,
    parameter int DATA_W = AXI4_DATA_W
) (
    input  logic              clk,
    input  logic              rst,

    input  logic [ADDR_W-1:0] s0_araddr,
    input  logic [2:0]        s0_arprot,
    input  logic              s0_arvalid,
    output logic              s0_arready,
    output logic [DATA_W-1:0] s0_rdata,
    output logic [1:0]        s0_rresp,
    output logic              s0_rvalid,
    input  logic              s0_rready,

    input  logic [ADDR_W-1:0] s1_araddr,
    input  logic [2:0]        s1_arprot,
    input  logic              s1_arvalid,
    output logic              s1_arready,
    output logic [DATA_W-1:0] s1_rdata,
    output logic [1:0]        s1_rresp,
    output logic              s1_rvalid,
    input  logic              s1_rready,

    output logic [ADDR_W-1:0] m_araddr,
    output logic [2:0]        m_arprot,
    output logic              m_arvalid,
    input  logic              m_arready,
    input  logic [DATA_W-1:0] m_rdata,
    input  logic [1:0]        m_rresp,
    input  logic              m_rvalid,
    output logic              m_rready,

    output logic              busy,
    output logic              grant
);

    arb_state_t        r_state;
    logic              r_last;
    logic              r_grant;
    logic [ADDR_W-1:0] r_addr;
    logic [2:0]        r_prot;

    logic              w_gnt_valid;
    logic              w_gnt_idx;
    logic              w_idle;
    logic              w_data;
    logic              w_r_hs;

    axi4_rr_pick2 u_pick (
        .req       ({s1_arvalid, s0_arvalid}),
        .last      (r_last),
        .gnt_valid (w_gnt_valid),
        .gnt_idx   (w_gnt_idx)
    );

    assign w_idle = (r_state == ST_IDLE);
    assign w_data = (r_state == ST_DATA);
    assign w_r_hs = m_rvalid & m_rready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_last  <= 1'b1;
            r_grant <= 1'b0;
            r_addr  <= '0;
            r_prot  <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_gnt_valid) begin
                        r_grant <= w_gnt_idx;
                        r_addr  <= w_gnt_idx ? s1_araddr : s0_araddr;
                        r_prot  <= w_gnt_idx ? s1_arprot : s0_arprot;
                        r_state <= ST_ADDR;
                    end
                end
                ST_ADDR: begin
                    if (m_arready) begin
                        r_state <= ST_DATA;
                    end
                end
                ST_DATA: begin
                    if (w_r_hs) begin
                        r_last  <= r_grant;
                        r_grant <= 1'b0;
                        r_state <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    // The winner is accepted in the same cycle it is picked; rst masks it.
    assign s0_arready = ~rst & w_idle & w_gnt_valid & ~w_gnt_idx;
    assign s1_arready = ~rst & w_idle & w_gnt_valid &  w_gnt_idx;

    assign m_araddr  = r_addr;
    assign m_arprot  = r_prot;
    assign m_arvalid = (r_state == ST_ADDR);

    assign m_rready  = w_data & (r_grant ? s1_rready : s0_rready);
    assign s0_rvalid = w_data & ~r_grant & m_rvalid;
    assign s1_rvalid = w_data &  r_grant & m_rvalid;
    assign s0_rdata  = m_rdata;
    assign s1_rdata  = m_rdata;
    assign s0_rresp  = m_rresp;
    assign s1_rresp  = m_rresp;

    assign busy  = ~w_idle;
    assign grant = r_grant;

endmodule
